mem_arbiter: RTL and testbench

// Sits directly downstream of the CPU top. Merges its two wishbone masters (ifetch, memory)

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_mux.sv | 48 ++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master wishbone line arbiter.
// Default bus widths and watchdog length live here.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W  = 12;
    localparam int ARB_DATA_W  = 128;
    localparam int ARB_SEL_W   = ARB_DATA_W / 8;
    localparam int ARB_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-beat wishbone line bus between a master and a slave.
// Modports are named from the side that plays each role.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int SEL_W  = ARB_SEL_W
) ();

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat_m;
    logic              ack;
    logic [DATA_W-1:0] dat_s;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  ack, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output ack, dat_s
    );

endinterface

// File: rtl/mem_arbiter_mux.sv
// Steers the granted master onto pmem and routes ACK back to it.
// Purely combinational; selection comes from the registered arbiter state.
module mem_arbiter_mux
    import mem_arbiter_pkg::*;
(
    input  arb_state_t    state,
    mem_arbiter_if.slave  ifetch,
    mem_arbiter_if.slave  memory,
    mem_arbiter_if.master pmem
);

    always_comb begin
        pmem.cyc   = 1'b0;
        pmem.stb   = 1'b0;
        pmem.we    = 1'b0;
        pmem.adr   = '0;
        pmem.sel   = '0;
        pmem.dat_m = '0;
        ifetch.ack = 1'b0;
        memory.ack = 1'b0;
        unique case (state)
            ARB_SERVE_I: begin
                pmem.cyc   = ifetch.cyc;
                pmem.stb   = ifetch.stb;
                pmem.we    = ifetch.we;
                pmem.adr   = ifetch.adr;
                pmem.sel   = ifetch.sel;
                pmem.dat_m = ifetch.dat_m;
                ifetch.ack = pmem.ack;
            end
            ARB_SERVE_D: begin
                pmem.cyc   = memory.cyc;
                pmem.stb   = memory.stb;
                pmem.we    = memory.we;
                pmem.adr   = memory.adr;
                pmem.sel   = memory.sel;
                pmem.dat_m = memory.dat_m;
                memory.ack = pmem.ack;
            end
            default: ;
        endcase
    end

    // Read data is shared; only the ACK tells a master it is theirs.
    assign ifetch.dat_s = pmem.dat_s;
    assign memory.dat_s = pmem.dat_s;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging ifetch and memory onto one pmem port,
// grant held until ACK, with a sticky no-ACK watchdog flag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  ifetch,
    mem_arbiter_if.slave  memory,
    mem_arbiter_if.master pmem,
    output logic          arb_timeout
);

    localparam int             WD_W   = $clog2(TIMEOUT + 2);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    arb_state_t      state;
    arb_grant_t      last_grant;
    logic [WD_W-1:0] wd_cnt;
    logic            req_i;
    logic            req_d;
    logic            gnt_cyc;
    logic            stall;
    logic            wd_hit;

    assign req_i = ifetch.cyc & ifetch.stb;
    assign req_d = memory.cyc & memory.stb;

    assign gnt_cyc = (state == ARB_SERVE_I) ? ifetch.cyc
                   : (state == ARB_SERVE_D) & memory.cyc;
    assign stall   = gnt_cyc & ~pmem.ack;
    assign wd_hit  = (TIMEOUT != 0) && stall && (wd_cnt == WD_MAX - WD_ONE);

    // On ACK the waiting master takes over directly, so no IDLE bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= GNT_I;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (req_d && (!req_i || last_grant == GNT_I)) begin
                        state      <= ARB_SERVE_D;
                        last_grant <= GNT_D;
                    end else if (req_i) begin
                        state      <= ARB_SERVE_I;
                        last_grant <= GNT_I;
                    end
                end
                ARB_SERVE_I: begin
                    if (pmem.ack) begin
                        if (req_d) begin
                            state      <= ARB_SERVE_D;
                            last_grant <= GNT_D;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end else if (!ifetch.cyc) begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_SERVE_D: begin
                    if (pmem.ack) begin
                        if (req_i) begin
                            state      <= ARB_SERVE_I;
                            last_grant <= GNT_I;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end else if (!memory.cyc) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Any cycle that is not a stalled grant (idle, ACK, abort) restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            arb_timeout <= 1'b0;
        end else begin
            if (!stall) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end
            if (wd_hit) begin
                arb_timeout <= 1'b1;
            end
        end
    end

    mem_arbiter_mux u_mux (
        .state  (state),
        .ifetch (ifetch),
        .memory (memory),
        .pmem   (pmem)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random bench for mem_arbiter against an owner-tracking
// reference model evaluated once per clock.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 8;
    localparam int MI = 0;
    localparam int MD = 1;
    localparam logic [127:0] DD  = 128'hDEAD_C0DE_0123_4567_89AB_CDEF_FEED_BEEF;
    localparam logic [127:0] PAT = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         arb_timeout;
    logic         ack_want = 1'b0;
    logic         ack_force = 1'b0;
    logic [127:0] slave_dat = '0;

    mem_arbiter_if ifetch_bus ();
    mem_arbiter_if memory_bus ();
    mem_arbiter_if pmem_bus ();

    // A well-behaved slave only ACKs a live strobe; ack_force injects strays.
    assign pmem_bus.ack   = ack_force | (ack_want & pmem_bus.cyc & pmem_bus.stb);
    assign pmem_bus.dat_s = slave_dat;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifetch      (ifetch_bus),
        .memory      (memory_bus),
        .pmem        (pmem_bus),
        .arb_timeout (arb_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int m, bit req, bit we = 1'b0,
                         logic [11:0] adr = '0, logic [15:0] sel = '0,
                         logic [127:0] dat = '0);
        if (m == MI) begin
            ifetch_bus.cyc   = req;
            ifetch_bus.stb   = req;
            ifetch_bus.we    = we;
            ifetch_bus.adr   = adr;
            ifetch_bus.sel   = sel;
            ifetch_bus.dat_m = dat;
        end else begin
            memory_bus.cyc   = req;
            memory_bus.stb   = req;
            memory_bus.we    = we;
            memory_bus.adr   = adr;
            memory_bus.sel   = sel;
            memory_bus.dat_m = dat;
        end
    endtask

    // Reference model: owner 0 = nobody, 1 = ifetch, 2 = memory.
    int  owner = 0;
    int  last = 1;
    int  stall_cycles = 0;
    bit  flag = 1'b0;
    bit  acked_i = 1'b0;
    bit  acked_d = 1'b0;
    bit  pack, ri, rd, oc;
    logic [30:0]  e_ctl;
    logic [127:0] e_dat;

    function automatic int pick(bit req_i, bit req_d, int prev);
        if (req_i && req_d) return (prev == 1) ? 2 : 1;
        if (req_d) return 2;
        if (req_i) return 1;
        return 0;
    endfunction

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            pack = pmem_bus.ack;
            ri = ifetch_bus.cyc & ifetch_bus.stb;
            rd = memory_bus.cyc & memory_bus.stb;
            e_ctl = '0;
            e_dat = '0;
            oc = 1'b0;
            if (owner == 1) begin
                e_ctl = {ifetch_bus.cyc, ifetch_bus.stb, ifetch_bus.we,
                         ifetch_bus.adr, ifetch_bus.sel};
                e_dat = ifetch_bus.dat_m;
                oc = ifetch_bus.cyc;
            end else if (owner == 2) begin
                e_ctl = {memory_bus.cyc, memory_bus.stb, memory_bus.we,
                         memory_bus.adr, memory_bus.sel};
                e_dat = memory_bus.dat_m;
                oc = memory_bus.cyc;
            end
            chk("pmem_ctl", {pmem_bus.cyc, pmem_bus.stb, pmem_bus.we,
                             pmem_bus.adr, pmem_bus.sel}, e_ctl);
            chk("pmem_dat_m", pmem_bus.dat_m, e_dat);
            chk("acks", {ifetch_bus.ack, memory_bus.ack},
                {owner == 1 && pack, owner == 2 && pack});
            chk("dat_s_i", ifetch_bus.dat_s, slave_dat);
            chk("dat_s_d", memory_bus.dat_s, slave_dat);
            chk("timeout", arb_timeout, flag);
            acked_i = ifetch_bus.ack;
            acked_d = memory_bus.ack;
            if (!rst_n) begin
                owner = 0;
                last = 1;
                stall_cycles = 0;
                flag = 1'b0;
            end else if (owner == 0) begin
                owner = pick(ri, rd, last);
                if (owner != 0) last = owner;
                stall_cycles = 0;
            end else if (pack) begin
                if ((owner == 1 && rd) || (owner == 2 && ri)) begin
                    owner = 3 - owner;
                    last = owner;
                end else begin
                    owner = 0;
                end
                stall_cycles = 0;
            end else if (!oc) begin
                owner = 0;
                stall_cycles = 0;
            end else begin
                stall_cycles++;
                if (TO > 0 && stall_cycles >= TO) flag = 1'b1;
            end
        end
    end

    bit act[2];
    bit got;

    initial begin
        drive(MI, 1'b1, 1'b0, 12'h001, 16'hFFFF, '0);
        drive(MD, 1'b1, 1'b0, 12'h002, 16'hFFFF, '0);
        // Reset held with both requesting
        repeat (2) begin
            @(negedge clk);
            chk("rst_cyc", pmem_bus.cyc, 1'b0);
            chk("rst_acks", {ifetch_bus.ack, memory_bus.ack}, 2'b00);
            chk("rst_to", arb_timeout, 1'b0);
        end
        tick();
        rst_n = 1'b1;
        drive(MI, 1'b0);
        // Lone read
        drive(MD, 1'b1, 1'b0, 12'h0A5, 16'hFFFF, '0);
        slave_dat = DD;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 3) ack_want = 1'b1;
            if (c == 4) begin
                ack_want = 1'b0;
                drive(MD, 1'b0);
            end
            @(negedge clk);
            if (c == 1) chk("t2_adr", {pmem_bus.cyc, pmem_bus.adr}, {1'b1, 12'h0A5});
            chk("t2_ack_d", memory_bus.ack, c == 3);
            chk("t2_ack_i", ifetch_bus.ack, 1'b0);
            if (c == 3) chk("t2_dat", memory_bus.dat_s, DD);
            tick();
        end
        // Tie after reset: data first, then ifetch with no bubble
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(MI, 1'b1, 1'b0, 12'h111, 16'hFFFF, '0);
        drive(MD, 1'b1, 1'b0, 12'h222, 16'hFFFF, '0);
        tick();
        ack_want = 1'b1;
        @(negedge clk);
        chk("t3_first", {pmem_bus.adr, memory_bus.ack}, {12'h222, 1'b1});
        tick();
        drive(MD, 1'b0);
        @(negedge clk);
        chk("t3_handoff", {pmem_bus.cyc, pmem_bus.adr, ifetch_bus.ack},
            {1'b1, 12'h111, 1'b1});
        tick();
        ack_want = 1'b0;
        drive(MI, 1'b0);
        drive(MD, 1'b1, 1'b0, 12'h333, 16'hFFFF, '0);
        tick();
        ack_want = 1'b1;
        tick();
        ack_want = 1'b0;
        drive(MD, 1'b0);
        tick();
        drive(MI, 1'b1, 1'b0, 12'h444, 16'hFFFF, '0);
        drive(MD, 1'b1, 1'b0, 12'h555, 16'hFFFF, '0);
        tick();
        ack_want = 1'b1;
        @(negedge clk);
        chk("t3_tie2", {pmem_bus.adr, ifetch_bus.ack}, {12'h444, 1'b1});
        tick();
        drive(MI, 1'b0);
        @(negedge clk);
        chk("t3_tie2_next", {pmem_bus.adr, memory_bus.ack}, {12'h555, 1'b1});
        tick();
        ack_want = 1'b0;
        drive(MD, 1'b0);
        tick();
        // Write pass-through while ifetch waits
        drive(MD, 1'b1, 1'b1, 12'h0F0, 16'h00F0, PAT);
        tick();
        drive(MI, 1'b1, 1'b0, 12'h777, 16'hFFFF, '0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("t4_wr", {pmem_bus.we, pmem_bus.sel, pmem_bus.dat_m},
                {1'b1, 16'h00F0, PAT});
            chk("t4_i_wait", ifetch_bus.ack, 1'b0);
            tick();
        end
        ack_want = 1'b1;
        @(negedge clk);
        chk("t4_ack", {memory_bus.ack, pmem_bus.adr}, {1'b1, 12'h0F0});
        tick();
        drive(MD, 1'b0);
        @(negedge clk);
        chk("t4_next", {pmem_bus.we, pmem_bus.adr, ifetch_bus.ack},
            {1'b0, 12'h777, 1'b1});
        tick();
        ack_want = 1'b0;
        drive(MI, 1'b0);
        tick();
        // Abort, then a stray ACK in idle
        drive(MI, 1'b1, 1'b0, 12'h0AB, 16'hFFFF, '0);
        tick();
        tick();
        drive(MI, 1'b0);
        @(negedge clk);
        chk("t5_abort_cyc", pmem_bus.cyc, 1'b0);
        tick();
        ack_force = 1'b1;
        @(negedge clk);
        chk("t5_stray", {pmem_bus.cyc, ifetch_bus.ack, memory_bus.ack}, 3'b000);
        tick();
        ack_force = 1'b0;
        // Reset mid-transfer
        drive(MD, 1'b1, 1'b0, 12'h0CD, 16'hFFFF, '0);
        tick();
        @(negedge clk);
        chk("t5_live", {pmem_bus.cyc, pmem_bus.adr}, {1'b1, 12'h0CD});
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_killed", {pmem_bus.cyc, pmem_bus.adr, memory_bus.ack},
            {1'b0, 12'h000, 1'b0});
        tick();
        rst_n = 1'b1;
        drive(MD, 1'b0);
        tick();
        // Watchdog
        drive(MD, 1'b1, 1'b0, 12'h0EE, 16'hFFFF, '0);
        tick();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("t6_flag", arb_timeout, c > TO);
            tick();
        end
        ack_want = 1'b1;
        @(negedge clk);
        chk("t6_late_ack", memory_bus.ack, 1'b1);
        tick();
        ack_want = 1'b0;
        drive(MD, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("t6_sticky", {arb_timeout, pmem_bus.cyc}, 2'b10);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_cleared", arb_timeout, 1'b0);
        tick();
        // Random traffic
        act[0] = 1'b0;
        act[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            ack_want = ($urandom_range(0, 2) == 0);
            slave_dat = {$urandom, $urandom, $urandom, $urandom};
            for (int m = 0; m < 2; m++) begin
                got = (m == MI) ? acked_i : acked_d;
                if (act[m] && (got || $urandom_range(0, 63) == 0)) begin
                    act[m] = 1'b0;
                    drive(m, 1'b0);
                end else if (!act[m] && $urandom_range(0, 2) == 0) begin
                    act[m] = 1'b1;
                    drive(m, 1'b1, 1'($urandom_range(0, 1)), 12'($urandom),
                          16'($urandom), {$urandom, $urandom, $urandom, $urandom});
                end
            end
            tick();
        end
        rst_n = 1'b1;
        ack_want = 1'b0;
        drive(MI, 1'b0);
        drive(MD, 1'b0);
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
